cond_unit_banked: RTL and testbench

COND_UNIT_BANKED -- requirements
Module: cond_unit_banked

---
 rtl/cond_unit_banked.sv | 150 +++++++++++++++
 tb/tb_cond_unit_banked.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_banked.sv
// Banked NZCV condition unit: evaluates a 4-bit condition on stored flags and gates write/branch strobes.
// Optional conditional-block FSM (IDLE/ACTIVE) is built only when COND_BLOCK_EN is defined.
module cond_unit_banked #(
  parameter int NBANKS  = 2,
  parameter int MAX_BLK = 4,
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int LW = $clog2(MAX_BLK + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] bank_sel,
  input  logic          instr_valid,
  input  logic [3:0]    cond,
  input  logic [3:0]    alu_flags,
  input  logic [1:0]    flag_w,
  input  logic          reg_w_in,
  input  logic          mem_w_in,
  input  logic          pc_s_in,
  input  logic          blk_start,
  input  logic [3:0]    blk_cond,
  input  logic [LW-1:0] blk_len,
  output logic          reg_w,
  output logic          mem_w,
  output logic          pc_s,
  output logic          cond_ex,
  output logic [3:0]    flags_out,
  output logic          blk_active,
  output logic [LW-1:0] blk_rem
);

  // Flag word layout is {N, Z, C, V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    r  = 1'b1;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [3:0]    bank_q [NBANKS];
  logic [BW-1:0] sel_idx;
  logic [3:0]    cur_flags;
  logic [3:0]    eff_cond;

  // Out-of-range bank selects fall back to bank 0.
  always_comb begin
    sel_idx = '0;
    if (int'(bank_sel) < NBANKS) sel_idx = bank_sel;
  end

  assign cur_flags = bank_q[sel_idx];
  assign flags_out = cur_flags;
  assign cond_ex   = instr_valid & eval_cond(eff_cond, cur_flags);
  assign reg_w     = reg_w_in & cond_ex;
  assign mem_w     = mem_w_in & cond_ex;
  assign pc_s      = pc_s_in  & cond_ex;

  // Only the selected bank is written, and only by an instruction that executes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANKS; i++) bank_q[i] <= 4'b0000;
    end else if (cond_ex) begin
      if (flag_w[1]) bank_q[sel_idx][3:2] <= alu_flags[3:2];
      if (flag_w[0]) bank_q[sel_idx][1:0] <= alu_flags[1:0];
    end
  end

`ifdef COND_BLOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } blk_state_t;

  blk_state_t    state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [3:0]    bcond_q, bcond_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bcond_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bcond_q <= bcond_d;
    end
  end

  // The start instruction itself is not part of the block; block members follow it.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bcond_d = bcond_q;
    case (state_q)
      IDLE: begin
        if (instr_valid && blk_start && (blk_len != '0)) begin
          state_d = ACTIVE;
          bcond_d = blk_cond;
          rem_d   = (blk_len > LW'(MAX_BLK)) ? LW'(MAX_BLK) : blk_len;
        end
      end
      ACTIVE: begin
        if (instr_valid) begin
          if (rem_q <= LW'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - LW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign blk_active = (state_q == ACTIVE);
  assign blk_rem    = rem_q;
  assign eff_cond   = blk_active ? bcond_q : cond;
`else
  wire unused_blk = ^{blk_start, blk_cond, blk_len};

  assign blk_active = 1'b0;
  assign blk_rem    = '0;
  assign eff_cond   = cond;
`endif

endmodule

// File: tb/tb_cond_unit_banked.sv
// Directed bench for cond_unit_banked: vector table for evaluation/flag banking plus
// hand sequences for reset and conditional-block behaviour (selected by COND_BLOCK_EN).
module tb_cond_unit_banked;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:0]    bank_sel;
  logic          instr_valid;
  logic [3:0]    cond, alu_flags, blk_cond;
  logic [1:0]    flag_w;
  logic          reg_w_in, mem_w_in, pc_s_in, blk_start;
  logic [LW-1:0] blk_len, blk_rem;
  logic          reg_w, mem_w, pc_s, cond_ex, blk_active;
  logic [3:0]    flags_out;

  int errors = 0;
  int checks = 0;

  cond_unit_banked #(.NBANKS(2), .MAX_BLK(4)) dut (
    .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .instr_valid(instr_valid),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
    .reg_w_in(reg_w_in), .mem_w_in(mem_w_in), .pc_s_in(pc_s_in),
    .blk_start(blk_start), .blk_cond(blk_cond), .blk_len(blk_len),
    .reg_w(reg_w), .mem_w(mem_w), .pc_s(pc_s), .cond_ex(cond_ex),
    .flags_out(flags_out), .blk_active(blk_active), .blk_rem(blk_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:0] bank;
    logic       valid;
    logic [3:0] cnd;
    logic [3:0] alu;
    logic [1:0] fw;
    logic [2:0] str;
    logic       ex;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic [0:0] b, input logic v, input logic [3:0] c,
                              input logic [3:0] a, input logic [1:0] fw, input logic [2:0] s,
                              input logic ex, input logic [3:0] f);
    vec_t r;
    r.bank = b; r.valid = v; r.cnd = c; r.alu = a; r.fw = fw; r.str = s; r.ex = ex; r.flags = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one instruction slot at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [0:0] b, input logic v, input logic [3:0] c,
                       input logic [3:0] a, input logic [1:0] fw, input logic [2:0] s,
                       input logic bs, input logic [3:0] bc, input logic [LW-1:0] bl);
    @(negedge clk);
    bank_sel = b; instr_valid = v; cond = c; alu_flags = a; flag_w = fw;
    {reg_w_in, mem_w_in, pc_s_in} = s;
    blk_start = bs; blk_cond = bc; blk_len = bl;
    #1;
  endtask

  task automatic check_blk(input string name, input logic ex, input logic act, input logic [LW-1:0] rem);
    check({name, " cond_ex"}, 32'(cond_ex), 32'(ex));
    check({name, " blk_active"}, 32'(blk_active), 32'(act));
    check({name, " blk_rem"}, 32'(blk_rem), 32'(rem));
  endtask

  initial begin
    // Flags {N,Z,C,V}; strobes {reg,mem,pc}.
    tbl[0]  = mk(1'b0, 1, 4'b0000, 4'b0000, 2'b00, 3'b100, 0, 4'b0000);
    tbl[1]  = mk(1'b0, 1, 4'b0001, 4'b0000, 2'b00, 3'b110, 1, 4'b0000);
    tbl[2]  = mk(1'b0, 1, 4'b1110, 4'b0100, 2'b11, 3'b000, 1, 4'b0000);
    tbl[3]  = mk(1'b0, 1, 4'b0000, 4'b0000, 2'b00, 3'b001, 1, 4'b0100);
    tbl[4]  = mk(1'b1, 1, 4'b0000, 4'b0000, 2'b00, 3'b111, 0, 4'b0000);
    tbl[5]  = mk(1'b1, 0, 4'b1110, 4'b1111, 2'b11, 3'b111, 0, 4'b0000);
    tbl[6]  = mk(1'b1, 1, 4'b1110, 4'b1000, 2'b10, 3'b000, 1, 4'b0000);
    tbl[7]  = mk(1'b1, 1, 4'b1010, 4'b0000, 2'b00, 3'b100, 0, 4'b1000);
    tbl[8]  = mk(1'b1, 1, 4'b1011, 4'b0000, 2'b00, 3'b010, 1, 4'b1000);
    tbl[9]  = mk(1'b1, 1, 4'b1100, 4'b0000, 2'b00, 3'b000, 0, 4'b1000);
    tbl[10] = mk(1'b1, 1, 4'b1101, 4'b0000, 2'b00, 3'b000, 1, 4'b1000);
    tbl[11] = mk(1'b1, 1, 4'b1010, 4'b0111, 2'b11, 3'b111, 0, 4'b1000);
    tbl[12] = mk(1'b1, 1, 4'b0100, 4'b0011, 2'b01, 3'b000, 1, 4'b1000);
    tbl[13] = mk(1'b1, 1, 4'b0010, 4'b0000, 2'b00, 3'b000, 1, 4'b1011);
    tbl[14] = mk(1'b1, 1, 4'b0111, 4'b0000, 2'b00, 3'b000, 0, 4'b1011);
    tbl[15] = mk(1'b1, 1, 4'b1010, 4'b0000, 2'b00, 3'b000, 1, 4'b1011);
    tbl[16] = mk(1'b1, 1, 4'b1000, 4'b0000, 2'b00, 3'b000, 1, 4'b1011);
    tbl[17] = mk(1'b1, 1, 4'b1001, 4'b0000, 2'b00, 3'b000, 0, 4'b1011);
    tbl[18] = mk(1'b0, 1, 4'b0101, 4'b0000, 2'b00, 3'b000, 1, 4'b0100);
    tbl[19] = mk(1'b0, 1, 4'b0011, 4'b1010, 2'b01, 3'b000, 1, 4'b0100);
    tbl[20] = mk(1'b0, 1, 4'b0110, 4'b0000, 2'b00, 3'b000, 0, 4'b0110);
    tbl[21] = mk(1'b0, 1, 4'b1111, 4'b0000, 2'b00, 3'b101, 1, 4'b0110);
    tbl[22] = mk(1'b0, 1, 4'b1000, 4'b0000, 2'b00, 3'b000, 0, 4'b0110);
    tbl[23] = mk(1'b1, 1, 4'b1110, 4'b0000, 2'b00, 3'b000, 1, 4'b1011);
    tbl[24] = mk(1'b0, 1, 4'b1001, 4'b0000, 2'b00, 3'b010, 1, 4'b0110);

    // Reset state: zero flags, ~Z passes on zero flags.
    rst_n = 1'b0; bank_sel = 1'b0; instr_valid = 1'b1; cond = 4'b0001; alu_flags = 4'b0;
    flag_w = 2'b00; {reg_w_in, mem_w_in, pc_s_in} = 3'b100;
    blk_start = 1'b0; blk_cond = 4'b0; blk_len = '0;
    #3;
    check("reset flags_out", 32'(flags_out), 32'h0);
    check("reset cond_ex", 32'(cond_ex), 32'h1);
    check("reset reg_w", 32'(reg_w), 32'h1);
    check("reset blk_active", 32'(blk_active), 32'h0);
    check("reset blk_rem", 32'(blk_rem), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].bank, tbl[i].valid, tbl[i].cnd, tbl[i].alu, tbl[i].fw, tbl[i].str, 1'b0, 4'b0, '0);
      check($sformatf("vec%0d cond_ex", i), 32'(cond_ex), 32'(tbl[i].ex));
      check($sformatf("vec%0d strobes", i), 32'({reg_w, mem_w, pc_s}),
            32'(tbl[i].ex ? tbl[i].str : 3'b000));
      check($sformatf("vec%0d flags_out", i), 32'(flags_out), 32'(tbl[i].flags));
      check($sformatf("vec%0d blk_active", i), 32'(blk_active), 32'h0);
    end

    // Asynchronous reset clears banks without waiting for a clock edge.
    drive(1'b0, 1, 4'b1110, 4'b0000, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check("pre-rst bank0", 32'(flags_out), 32'h6);
    #2 rst_n = 1'b0;
    #1 check("async rst bank0", 32'(flags_out), 32'h0);
    bank_sel = 1'b1;
    #1 check("async rst bank1", 32'(flags_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef COND_BLOCK_EN
    // Block of 3 under ~Z; members carry cond=Z which alone would fail.
    drive(1'b0, 1, 4'b1110, 4'b0, 2'b00, 3'b100, 1'b1, 4'b0001, 3'd3);
    check_blk("blk start", 1, 0, 3'd0);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("blk i1", 1, 1, 3'd3);
    check("blk i1 reg_w", 32'(reg_w), 32'h1);
    drive(1'b0, 0, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("blk bubble", 0, 1, 3'd2);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("blk i2", 1, 1, 3'd2);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("blk i3", 1, 1, 3'd1);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("blk after", 0, 0, 3'd0);

    // Length clamp, ignored nested start, then reset mid-block.
    drive(1'b0, 1, 4'b1110, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0001, 3'd7);
    check_blk("clamp start", 1, 0, 3'd0);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0000, 3'd1);
    check_blk("clamp i1", 1, 1, 3'd4);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("clamp i2", 1, 1, 3'd3);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("clamp i3", 1, 1, 3'd2);
    #2 rst_n = 1'b0;
    #1 check("abort blk_active", 32'(blk_active), 32'h0);
    check("abort blk_rem", 32'(blk_rem), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("post abort", 0, 0, 3'd0);

    // In-block flag write and bank switch change member evaluation.
    drive(1'b0, 1, 4'b1110, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0001, 3'd3);
    check_blk("fl start", 1, 0, 3'd0);
    drive(1'b0, 1, 4'b1110, 4'b0100, 2'b10, 3'b000, 1'b0, 4'b0, '0);
    check_blk("fl i1", 1, 1, 3'd3);
    drive(1'b0, 1, 4'b1110, 4'b0000, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("fl i2", 0, 1, 3'd2);
    drive(1'b1, 1, 4'b1110, 4'b0000, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("fl i3 bank1", 1, 1, 3'd1);
    drive(1'b0, 1, 4'b1110, 4'b0000, 2'b00, 3'b000, 1'b0, 4'b0, '0);
    check_blk("fl after", 1, 0, 3'd0);
`else
    // Block inputs have no effect without the block feature.
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b1, 4'b0001, 3'd3);
    check_blk("noblk start", 0, 0, 3'd0);
    check("noblk reg_w", 32'(reg_w), 32'h0);
    drive(1'b0, 1, 4'b0000, 4'b0, 2'b00, 3'b100, 1'b0, 4'b0, '0);
    check_blk("noblk next", 0, 0, 3'd0);
    drive(1'b0, 1, 4'b0001, 4'b0, 2'b00, 3'b100, 1'b1, 4'b0000, 3'd2);
    check_blk("noblk own cond", 1, 0, 3'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
